// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and constants for the LC-3 memory-port arbiter.
package lc3_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int MAX_WAIT   = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU_ACC  = 3'd1,
    ST_DMA_ACC  = 3'd2,
    ST_CPU_DONE = 3'd3,
    ST_DMA_DONE = 3'd4
  } state_t;

  function automatic logic is_acc(input state_t s);
    return (s == ST_CPU_ACC) || (s == ST_DMA_ACC);
  endfunction

  function automatic logic is_done(input state_t s);
    return (s == ST_CPU_DONE) || (s == ST_DMA_DONE);
  endfunction

endpackage

// File: rtl/lc3_mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant (CPU vs DMA) with a last-served register.
module lc3_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_dma,
  input  logic update,
  input  logic served_dma,
  output logic gnt_cpu,
  output logic gnt_dma
);

  // 1 = DMA was served last, so the CPU wins the next tie.
  logic last_gnt_r;

  // Remember which requester finished most recently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt_r <= 1'b1;
    end else if (update) begin
      last_gnt_r <= served_dma;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

  // Grant the sole requester, or the one not served last on a tie.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (req_cpu && req_dma) begin
      gnt_cpu = last_gnt_r;
      gnt_dma = !last_gnt_r;
    end else begin
      gnt_cpu = req_cpu;
      gnt_dma = req_dma;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// LC-3 memory-port controller: sequences CPU (and optional DMA) accesses
// over WAIT_CYCLES cycles. Macro LC3_MEM_DMA_EN enables the DMA port.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio_en,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_r,
  input  logic              dma_req,
  input  logic              dma_rw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              rw_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              ce_r, we_r, cpu_r_r;
  logic [DATA_W-1:0] cpu_rdata_r;

  logic              gnt_cpu_s, gnt_dma_s, grant_s, acc_last_s;
  logic              sel_rw_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

`ifdef LC3_MEM_DMA_EN
  logic              dma_done_r, dma_gnt_r;
  logic [DATA_W-1:0] dma_rdata_r;
  logic              arb_update_s, arb_served_dma_s;

  assign arb_update_s     = is_done(state_r);
  assign arb_served_dma_s = (state_r == ST_DMA_DONE);

  lc3_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_cpu    (cpu_mio_en),
    .req_dma    (dma_req),
    .update     (arb_update_s),
    .served_dma (arb_served_dma_s),
    .gnt_cpu    (gnt_cpu_s),
    .gnt_dma    (gnt_dma_s)
  );
`else
  logic unused_dma_s;

  assign unused_dma_s = ^{dma_req, dma_rw, dma_addr, dma_wdata};
  assign gnt_cpu_s    = cpu_mio_en;
  assign gnt_dma_s    = 1'b0;
`endif

  assign grant_s    = (state_r == ST_IDLE) && (gnt_cpu_s || gnt_dma_s);
  assign acc_last_s = is_acc(state_r) && (cnt_r == {CNT_W{1'b0}});

  // Pick the access fields of the requester being granted this cycle.
  always_comb begin
    sel_rw_s    = cpu_rw;
    sel_addr_s  = cpu_addr;
    sel_wdata_s = cpu_wdata;
`ifdef LC3_MEM_DMA_EN
    if (gnt_dma_s) begin
      sel_rw_s    = dma_rw;
      sel_addr_s  = dma_addr;
      sel_wdata_s = dma_wdata;
    end else begin
      sel_rw_s    = cpu_rw;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_cpu_s) begin
          state_s = ST_CPU_ACC;
        end else if (gnt_dma_s) begin
          state_s = ST_DMA_ACC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CPU_ACC: begin
        if (acc_last_s) state_s = ST_CPU_DONE;
        else            state_s = ST_CPU_ACC;
      end
      ST_CPU_DONE: state_s = ST_IDLE;
`ifdef LC3_MEM_DMA_EN
      ST_DMA_ACC: begin
        if (acc_last_s) state_s = ST_DMA_DONE;
        else            state_s = ST_DMA_ACC;
      end
      ST_DMA_DONE: state_s = ST_IDLE;
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // State, wait counter, latched access fields and registered CPU/memory outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      rw_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      ce_r        <= 1'b0;
      we_r        <= 1'b0;
      cpu_r_r     <= 1'b0;
      cpu_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        cnt_r   <= WAIT_LOAD;
        rw_r    <= sel_rw_s;
        addr_r  <= sel_addr_s;
        wdata_r <= sel_wdata_s;
      end else if (is_acc(state_r) && !acc_last_s) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      // Strobes are driven from the next state so they line up with the ACC cycles.
      ce_r    <= is_acc(state_s);
      we_r    <= is_acc(state_s) && (grant_s ? sel_rw_s : rw_r);
      cpu_r_r <= (state_s == ST_CPU_DONE);
      if ((state_r == ST_CPU_ACC) && acc_last_s && !rw_r) begin
        cpu_rdata_r <= mem_rdata;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
    end
  end

`ifdef LC3_MEM_DMA_EN
  // Registered DMA handshake outputs and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_done_r  <= 1'b0;
      dma_gnt_r   <= 1'b0;
      dma_rdata_r <= {DATA_W{1'b0}};
    end else begin
      dma_done_r <= (state_s == ST_DMA_DONE);
      dma_gnt_r  <= (state_s == ST_DMA_ACC) || (state_s == ST_DMA_DONE);
      if ((state_r == ST_DMA_ACC) && acc_last_s && !rw_r) begin
        dma_rdata_r <= mem_rdata;
      end else begin
        dma_rdata_r <= dma_rdata_r;
      end
    end
  end

  assign dma_done  = dma_done_r;
  assign dma_gnt   = dma_gnt_r;
  assign dma_rdata = dma_rdata_r;
`else
  assign dma_done  = 1'b0;
  assign dma_gnt   = 1'b0;
  assign dma_rdata = {DATA_W{1'b0}};
`endif

  assign cpu_rdata = cpu_rdata_r;
  assign cpu_r     = cpu_r_r;
  assign mem_ce    = ce_r;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed scoreboard bench for lc3_mem_arbiter (WAIT_CYCLES = 2).
module tb_lc3_mem_arbiter;

  localparam int W = 2;

  typedef struct {
    bit          is_dma;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_mio_en = 1'b0, cpu_rw = 1'b0;
  logic [15:0] cpu_addr = 16'h0000, cpu_wdata = 16'h0000;
  logic [15:0] cpu_rdata;
  logic        cpu_r;
  logic        dma_req = 1'b0, dma_rw = 1'b0;
  logic [15:0] dma_addr = 16'h0000, dma_wdata = 16'h0000;
  logic [15:0] dma_rdata;
  logic        dma_gnt, dma_done;
  logic        mem_ce, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          seen_dma = 1'b0;
  exp_t        sb_q[$];
  logic [15:0] exp_cpu_rdata = 16'h0000;
  int          c0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .cpu_mio_en(cpu_mio_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_r(cpu_r),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_gnt(dma_gnt), .dma_done(dma_done),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest expected access.
  always @(negedge clk) begin
    exp_t e;
    seen_dma = seen_dma | dma_gnt | dma_done;
    if (cpu_r || dma_done) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed=cpu_r:%b,dma_done:%b expected=none", cpu_r, dma_done);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("pulse_kind", {30'd0, cpu_r, dma_done}, {30'd0, !e.is_dma, e.is_dma});
        chk("pulse_cycle", cyc, e.cyc);
        if (e.is_dma) chk("dma_rdata", {16'd0, dma_rdata}, {16'd0, e.rdata});
        else          chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.rdata});
      end
    end
  end

  task automatic cpu_access(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] rd);
    @(negedge clk);
    cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata; mem_rdata = rd; cpu_mio_en = 1'b1;
    if (!rw) exp_cpu_rdata = rd;
    sb_q.push_back('{1'b0, exp_cpu_rdata, cyc + W + 1});
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge clk);
      if (i <= W) begin
        chk("acc_ce", {31'd0, mem_ce}, 32'd1);
        chk("acc_we", {31'd0, mem_we}, {31'd0, rw});
        chk("acc_addr", {16'd0, mem_addr}, {16'd0, addr});
        if (rw) chk("acc_wdata", {16'd0, mem_wdata}, {16'd0, wdata});
      end else begin
        chk("done_ce", {31'd0, mem_ce}, 32'd0);
      end
      if (i == 1) begin
        cpu_rw = ~rw; cpu_addr = ~addr; cpu_wdata = ~wdata;
      end
    end
    cpu_mio_en = 1'b0;
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifndef LC3_MEM_DMA_EN
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 16'h5555; dma_wdata = 16'hAAAA;
`endif
    #2;
    chk("rst_ce", {31'd0, mem_ce}, 32'd0);
    chk("rst_cpu_r", {31'd0, cpu_r}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    cpu_access(1'b0, 16'h3000, 16'h0000, 16'h1234);
    cpu_access(1'b1, 16'h4000, 16'hBEEF, 16'hDEAD);
    cpu_access(1'b0, 16'h3001, 16'h0000, 16'h5A5A);
    chk("rdata_hold", {16'd0, cpu_rdata}, 32'h5A5A);

    // Continuous CPU request: a new access after each IDLE cycle.
    @(negedge clk);
    c0 = cyc;
    cpu_rw = 1'b0; cpu_addr = 16'h5000; mem_rdata = 16'h0F0F; cpu_mio_en = 1'b1;
    exp_cpu_rdata = 16'h0F0F;
    sb_q.push_back('{1'b0, 16'h0F0F, c0 + 3});
    sb_q.push_back('{1'b0, 16'h0F0F, c0 + 7});
    repeat (7) @(negedge clk);
    cpu_mio_en = 1'b0;
    @(negedge clk);
    chk("cont_sb_empty", sb_q.size(), 32'd0);

    // Asynchronous reset in the first access cycle.
    @(negedge clk);
    cpu_rw = 1'b0; cpu_addr = 16'h3002; mem_rdata = 16'h2222; cpu_mio_en = 1'b1;
    sb_q.push_back('{1'b0, 16'h2222, cyc + W + 1});
    @(negedge clk);
    chk("pre_rst_ce", {31'd0, mem_ce}, 32'd1);
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_ce", {31'd0, mem_ce}, 32'd0);
    chk("mid_rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("mid_rst_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("mid_rst_cpu_r", {31'd0, cpu_r}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_cpu_rdata = 16'h2222;
    sb_q.push_back('{1'b0, 16'h2222, cyc + W + 1});
    repeat (W + 1) @(negedge clk);
    cpu_mio_en = 1'b0;
    @(negedge clk);
    chk("post_rst_sb_empty", sb_q.size(), 32'd0);

`ifdef LC3_MEM_DMA_EN
    // Tie after reset: CPU first, then alternate.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    c0 = cyc;
    cpu_rw = 1'b0; cpu_addr = 16'h1000; dma_rw = 1'b0; dma_addr = 16'h2000;
    mem_rdata = 16'h7777; cpu_mio_en = 1'b1; dma_req = 1'b1;
    sb_q.push_back('{1'b0, 16'h7777, c0 + 3});
    sb_q.push_back('{1'b1, 16'h7777, c0 + 7});
    sb_q.push_back('{1'b0, 16'h7777, c0 + 11});
    sb_q.push_back('{1'b1, 16'h7777, c0 + 15});
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("rr_dma_gnt", {31'd0, dma_gnt}, 32'd1);
        chk("rr_dma_addr", {16'd0, mem_addr}, 32'h2000);
      end
    end
    cpu_mio_en = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    chk("rr_sb_empty", sb_q.size(), 32'd0);

    // DMA write first, CPU request arrives one cycle later.
    @(negedge clk);
    c0 = cyc;
    dma_rw = 1'b1; dma_addr = 16'h6000; dma_wdata = 16'hCAFE; dma_req = 1'b1;
    sb_q.push_back('{1'b1, 16'h7777, c0 + 3});
    @(negedge clk);
    cpu_rw = 1'b0; cpu_addr = 16'h3003; mem_rdata = 16'h4444; cpu_mio_en = 1'b1;
    sb_q.push_back('{1'b0, 16'h4444, c0 + 7});
    chk("d_gnt", {31'd0, dma_gnt}, 32'd1);
    chk("d_we", {31'd0, mem_we}, 32'd1);
    chk("d_addr", {16'd0, mem_addr}, 32'h6000);
    chk("d_wdata", {16'd0, mem_wdata}, 32'hCAFE);
    repeat (2) @(negedge clk);
    chk("d_done_gnt", {31'd0, dma_gnt}, 32'd1);
    dma_req = 1'b0;
    @(negedge clk);
    chk("d_idle_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("d_idle_ce", {31'd0, mem_ce}, 32'd0);
    @(negedge clk);
    chk("c_ce", {31'd0, mem_ce}, 32'd1);
    chk("c_addr", {16'd0, mem_addr}, 32'h3003);
    chk("c_we", {31'd0, mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    cpu_mio_en = 1'b0;
    @(negedge clk);
    chk("dc_sb_empty", sb_q.size(), 32'd0);
`else
    chk("no_dma_activity", {31'd0, seen_dma}, 32'd0);
    chk("no_dma_rdata", {16'd0, dma_rdata}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("final_sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Memory-port controller and arbiter sitting between the LC-3 microsequencer/datapath and the single-ported main memory. It shares memory between the CPU (MIO_EN / R.W / MAR / MDR) and a DMA requester. It sequences each access over a fixed number of wait cycles and generates the one-cycle ready pulse `R` that the control FSM polls in its memory-wait states.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `WAIT_CYCLES`, 2, memory access length in cycles, legal range 1..15

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_mio_en`  in  1  CPU access request, level, held until `cpu_r`
- `cpu_rw`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  MAR
- `cpu_wdata`  in  DATA_W  MDR
- `cpu_rdata`  out  DATA_W  registered read data
- `cpu_r`  out  1  ready (R) pulse to control FSM
- `dma_req`  in  1  DMA request, level
- `dma_rw`, `dma_addr`, `dma_wdata`  in  1/ADDR_W/DATA_W  DMA access fields
- `dma_rdata`  out  DATA_W  registered DMA read data
- `dma_gnt`  out  1  high for the whole DMA access
- `dma_done`  out  1  one-cycle completion pulse
- `mem_ce`, `mem_we`  out  1  memory chip enable / write enable
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  memory address and write data
- `mem_rdata`  in  DATA_W  memory read data, valid by the last `mem_ce` cycle

## Operation
- FSM states: IDLE, CPU_ACC, DMA_ACC, CPU_DONE, DMA_DONE.
- IDLE:
  - Only `cpu_mio_en` high → CPU_ACC.
  - Only `dma_req` high → DMA_ACC.
  - Both high → grant to the requester not served last (1-bit `last_gnt`), then alternate.
  - Neither high → stay in IDLE.
- On grant, rw/addr/wdata are latched into `mem_*` registers. Requester input changes during the access are ignored.
- *_ACC:
  - `mem_ce` = 1 and `mem_we` = latched rw.
  - Wait counter loads `WAIT_CYCLES`-1 and decrements each cycle.
  - At 0, a read captures `mem_rdata` into the granted requester's rdata register; next state is *_DONE.
- *_DONE:
  - Pulse `cpu_r` or `dma_done` for exactly one cycle, update `last_gnt`, return to IDLE.
- `dma_gnt` is high in DMA_ACC and DMA_DONE.
- Request dropped mid-access: the access still completes and the done/R pulse is still issued.
- A request still high in the IDLE cycle after its DONE is treated as a new access.
- The rdata registers hold their value until the next read by the same requester completes. Writes leave rdata unchanged.
- Reset (asynchronous, any state):
  - State → IDLE; `last_gnt` = DMA, so the CPU wins the first tie.
  - All outputs and rdata registers → 0, counter → 0.

## Timing
- Request seen in IDLE at cycle 0 → ACC in cycles 1..WAIT_CYCLES → DONE (pulse) in cycle WAIT_CYCLES+1 → IDLE in cycle WAIT_CYCLES+2.
- Read data is valid on `*_rdata` in the pulse cycle.
- Minimum request-to-request spacing is WAIT_CYCLES+2 cycles. The mandatory IDLE cycle means no back-to-back grants.
- Each pulse is one cycle wide. The control FSM samples `cpu_r` on the same edge and leaves its wait state.
- `mem_ce` and `mem_we` are registered outputs, glitch-free.

## Configuration
- `LC3_MEM_DMA_EN` defined:
  - DMA port and round-robin arbitration active as above.
- Undefined:
  - DMA states and `last_gnt` removed; `dma_req`, `dma_rw`, `dma_addr` and `dma_wdata` ignored.
  - `dma_gnt`, `dma_done` and `dma_rdata` tied to 0.
  - CPU timing identical in both builds.

## Structure
- Shared package `lc3_mem_pkg`:
  - state enum
  - `ADDR_W` / `DATA_W` defaults
  - `MAX_WAIT` = 15 constant
- One sub-module: `lc3_rr_arb2`, a two-requester round-robin grant with `last_gnt` register. It is instantiated only under `LC3_MEM_DMA_EN`.

## Test plan
- CPU read, WAIT_CYCLES=2, `cpu_addr`=0x3000, `mem_rdata`=0x1234, request at cycle 0 → `mem_ce` high in cycles 1–2, `cpu_r` pulse in cycle 3 only, `cpu_rdata`=0x1234.
- CPU write to 0x4000 with data 0xBEEF → `mem_we`=1, `mem_addr`=0x4000, `mem_wdata`=0xBEEF in cycles 1–2, `cpu_r` in cycle 3, `cpu_rdata` unchanged.
- After reset, `cpu_mio_en` and `dma_req` both high continuously → grants in order CPU, DMA, CPU, DMA; each pulse 4 cycles apart.
- `dma_req` at cycle 0, `cpu_mio_en` from cycle 1 → `dma_done` in cycle 3, CPU_ACC in cycles 5–6, `cpu_r` in cycle 7.
- `reset` low during CPU_ACC cycle 1 → `mem_ce`=0 and all outputs 0 immediately. After release with `cpu_mio_en` still high, full access completes with `cpu_r` WAIT_CYCLES+1 cycles after the first IDLE cycle.
- Build without `LC3_MEM_DMA_EN`, `dma_req` tied to 1 → `dma_gnt` and `dma_done` never assert, CPU read latency remains 3 cycles.
